// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and the core's control decode.
// Class/ALU-op codes, RV32I opcodes, funct fields and the word assembly helper.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    ClsLoad  = 2'b00,
    ClsImm   = 2'b01,
    ClsStore = 2'b10,
    ClsReg   = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    FmtI,
    FmtIShift,
    FmtS,
    FmtR
  } instr_fmt_e;

  localparam logic [3:0] AluNone = 4'b0000;
  localparam logic [3:0] AluAdd  = 4'b0001;
  localparam logic [3:0] AluSub  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluOr   = 4'b0100;
  localparam logic [3:0] AluAnd  = 4'b0101;
  localparam logic [3:0] AluSll  = 4'b0110;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluSlt  = 4'b1010;
  localparam logic [3:0] AluSltu = 4'b1011;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcImm   = 7'b0010011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcReg   = 7'b0110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Word   = 3'b010;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  function automatic logic [31:0] assemble(input instr_fmt_e fmt, input logic [6:0] opcode,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [11:0] imm);
    logic [31:0] word;
    case (fmt)
      FmtIShift: word = {f7, imm[4:0], rs1, f3, rd, opcode};
      FmtS:      word = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      FmtR:      word = {f7, rs2, rs1, f3, rd, opcode};
      default:   word = {imm, rs1, f3, rd, opcode};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Tuple-in / word-out handshake bundle of the instruction encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [3:0]        in_alu_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [11:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_class, in_alu_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, in_class, in_alu_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );

endinterface

// File: rtl/instr_field_enc.sv
// Combinational class/ALU-op to opcode, funct fields, format and legality.
module instr_field_enc
  import instr_encoder_pkg::*;
(
  input  instr_class_e i_class,
  input  logic [3:0]   i_alu_op,
  output logic [6:0]   o_opcode,
  output logic [2:0]   o_funct3,
  output logic [6:0]   o_funct7,
  output instr_fmt_e   o_fmt,
  output logic         o_legal
);

  logic [2:0] w_f3;
  logic       w_alt;
  logic       w_shift;
  logic       w_arith_ok;

  always_comb begin
    w_f3       = F3AddSub;
    w_alt      = 1'b0;
    w_shift    = 1'b0;
    w_arith_ok = 1'b1;
    case (i_alu_op)
      AluAdd:  w_f3 = F3AddSub;
      AluSub:  w_alt = 1'b1;
      AluXor:  w_f3 = F3Xor;
      AluOr:   w_f3 = F3Or;
      AluAnd:  w_f3 = F3And;
      AluSll:  begin w_f3 = F3Sll; w_shift = 1'b1; end
      AluSrl:  begin w_f3 = F3Sr;  w_shift = 1'b1; end
      AluSra:  begin w_f3 = F3Sr;  w_shift = 1'b1; w_alt = 1'b1; end
      AluSlt:  w_f3 = F3Slt;
      AluSltu: w_f3 = F3Sltu;
      default: w_arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_opcode = OpcImm;
    o_funct3 = w_f3;
    o_funct7 = w_alt ? F7Alt : F7Base;
    o_fmt    = FmtI;
    o_legal  = 1'b0;
    unique case (i_class)
      ClsLoad: begin
        o_opcode = OpcLoad;
        o_funct3 = F3Word;
        o_funct7 = F7Base;
        o_legal  = (i_alu_op == AluAdd);
      end
      ClsImm: begin
        // SUB has no immediate form; shift-amount range is checked by the parent
        o_fmt   = w_shift ? FmtIShift : FmtI;
        o_legal = w_arith_ok && (i_alu_op != AluSub);
      end
      ClsStore: begin
        o_opcode = OpcStore;
        o_funct3 = F3Word;
        o_funct7 = F7Base;
        o_fmt    = FmtS;
        o_legal  = (i_alu_op == AluNone);
      end
      ClsReg: begin
        o_opcode = OpcReg;
        o_fmt    = FmtR;
        o_legal  = w_arith_ok;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with sequential word addressing and error counting.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  instr_fmt_e  w_fmt;
  logic        w_field_legal;
  logic        w_legal;
  logic [31:0] w_word;

  instr_field_enc u_field_enc (
    .i_class  (instr_class_e'(bus.in_class)),
    .i_alu_op (bus.in_alu_op),
    .o_opcode (w_opcode),
    .o_funct3 (w_f3),
    .o_funct7 (w_f7),
    .o_fmt    (w_fmt),
    .o_legal  (w_field_legal)
  );

  assign w_legal = w_field_legal && !((w_fmt == FmtIShift) && (bus.in_imm[11:5] != 7'd0));
  assign w_word  = assemble(w_fmt, w_opcode, w_f3, w_f7, bus.in_rd, bus.in_rs1, bus.in_rs2,
                            bus.in_imm);

  logic              r_alive;
  logic              r_s1_valid;
  logic              r_s1_legal;
  logic [31:0]       r_s1_word;
  logic              r_s2_valid;
  logic [31:0]       r_s2_word;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;

  logic w_s2_free;
  logic w_s1_adv;
  logic w_in_fire;
  logic w_s1_move;
  logic w_s1_drop;

  assign w_s2_free = !r_s2_valid || bus.out_ready;
  // Illegal entries leave S1 unconditionally; legal ones need room in S2
  assign w_s1_adv  = !r_s1_legal || w_s2_free;
  assign w_in_fire = bus.in_valid && bus.in_ready;
  assign w_s1_move = r_s1_valid && r_s1_legal && w_s2_free;
  assign w_s1_drop = r_s1_valid && !r_s1_legal;

  assign bus.in_ready  = r_alive && !start && (!r_s1_valid || w_s1_adv);
  assign bus.out_valid = r_s2_valid;
  assign bus.out_word  = r_s2_word;
  assign bus.out_addr  = r_addr;
  assign err_pulse     = r_err_pulse;
  assign err_count     = r_err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive     <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_legal  <= 1'b0;
      r_s1_word   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_word   <= '0;
      r_addr      <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_alive     <= 1'b1;
      r_err_pulse <= 1'b0;
      if (start) begin
        r_s1_valid  <= 1'b0;
        r_s2_valid  <= 1'b0;
        r_addr      <= base_addr;
        r_err_count <= '0;
      end else begin
        if (w_in_fire) begin
          r_s1_valid <= 1'b1;
          r_s1_legal <= w_legal;
          r_s1_word  <= w_word;
        end else if (r_s1_valid && w_s1_adv) begin
          r_s1_valid <= 1'b0;
        end
        if (w_s1_move) begin
          r_s2_valid <= 1'b1;
          r_s2_word  <= r_s1_word;
        end else if (bus.out_ready) begin
          r_s2_valid <= 1'b0;
        end
        if (r_s2_valid && bus.out_ready) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
        if (w_s1_drop) begin
          r_err_pulse <= 1'b1;
          if (!(&r_err_count)) begin
            r_err_count <= r_err_count + ERR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random tuples against an RV32I field-level model.
module tb_instr_encoder;

  localparam int unsigned AW = 8;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          err_pulse;
  logic [EW-1:0] err_count;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .ERR_W(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] m_addr = '0;
  int            exp_err = 0;
  int            seen_err = 0;
  bit            chk_en = 1'b0;
  int            rdy_mode = 0;
  bit            stall_pending = 1'b0;
  logic [31:0]   stall_word;
  logic [AW-1:0] stall_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32I semantics per mnemonic, composed with integer arithmetic
  function automatic void ref_enc(input logic [1:0] cls, input logic [3:0] op,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [11:0] imm,
                                  output bit legal, output logic [31:0] word);
    int f3, f7, i, d, s1, s2;
    bit arith, shift;
    i = int'(imm); d = int'(rd); s1 = int'(rs1); s2 = int'(rs2);
    arith = 1'b1; shift = 1'b0; f7 = 0; f3 = 0;
    case (op)
      4'd1:  f3 = 0;
      4'd2:  begin f3 = 0; f7 = 32; end
      4'd3:  f3 = 4;
      4'd4:  f3 = 6;
      4'd5:  f3 = 7;
      4'd6:  begin f3 = 1; shift = 1'b1; end
      4'd7:  begin f3 = 5; shift = 1'b1; end
      4'd9:  begin f3 = 5; f7 = 32; shift = 1'b1; end
      4'd10: f3 = 2;
      4'd11: f3 = 3;
      default: arith = 1'b0;
    endcase
    case (cls)
      2'd0: begin
        legal = (op == 4'd1);
        word  = 32'((i << 20) + (s1 << 15) + (2 << 12) + (d << 7) + 'h03);
      end
      2'd1: begin
        legal = arith && (op != 4'd2) && (!shift || (i >> 5) == 0);
        if (shift) word = 32'((f7 << 25) + ((i % 32) << 20) + (s1 << 15) + (f3 << 12) +
                              (d << 7) + 'h13);
        else       word = 32'((i << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + 'h13);
      end
      2'd2: begin
        legal = (op == 4'd0);
        word  = 32'(((i >> 5) << 25) + (s2 << 20) + (s1 << 15) + (2 << 12) +
                    ((i % 32) << 7) + 'h23);
      end
      default: begin
        legal = arith;
        word  = 32'((f7 << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + 'h33);
      end
    endcase
  endfunction

  // Called and returns at 1 time unit after a rising edge
  task automatic send(input logic [1:0] cls, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                      input bit directed, input logic [31:0] dword, input bit dlegal);
    bit          legal;
    logic [31:0] word;
    bit          ok;
    int          n;
    if (directed) begin
      legal = dlegal;
      word  = dword;
    end else begin
      ref_enc(cls, op, rd, rs1, rs2, imm, legal, word);
    end
    bus.in_valid = 1'b1; bus.in_class = cls; bus.in_alu_op = op;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    n = 0;
    do begin
      #1 ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 500);
    bus.in_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
    if (ok) begin
      if (legal) exp_q.push_back(word);
      else exp_err++;
    end
  endtask

  task automatic send_rand(input bit want_legal);
    logic [1:0] cls; logic [3:0] op; logic [4:0] rd, rs1, rs2; logic [11:0] imm;
    bit legal; logic [31:0] word;
    int tries = 0;
    do begin
      cls = 2'($urandom_range(0, 3));
      op  = 4'($urandom_range(0, 15));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      imm = 12'($urandom);
      if ($urandom_range(0, 1) == 1) imm = imm & 12'h01f;
      if (want_legal && cls == 2'd0) op = 4'd1;
      if (want_legal && cls == 2'd2) op = 4'd0;
      ref_enc(cls, op, rd, rs1, rs2, imm, legal, word);
      tries++;
    end while (want_legal && !legal && tries < 1000);
    send(cls, op, rd, rs1, rs2, imm, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    start = 1'b1;
    base_addr = b;
    #1 chk("in_ready_low_on_start", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    m_addr = b;
    exp_err = 0;
    seen_err = 0;
    chk("err_count_cleared", 32'(err_count), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      2:       bus.out_ready = 1'($urandom);
      default: bus.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      if (err_pulse) seen_err++;
      if (stall_pending) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_word", bus.out_word, stall_word);
        chk("stall_addr", 32'(bus.out_addr), 32'(stall_addr));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_word: got %h want none", bus.out_word);
        end else begin
          chk("out_word", bus.out_word, exp_q.pop_front());
          chk("out_addr", 32'(bus.out_addr), 32'(m_addr));
        end
        m_addr = m_addr + 1'b1;
        stall_pending = 1'b0;
      end else if (bus.out_valid) begin
        stall_pending = 1'b1;
        stall_word = bus.out_word;
        stall_addr = bus.out_addr;
      end else begin
        stall_pending = 1'b0;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_class = '0; bus.in_alu_op = '0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_word", bus.out_word, 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    chk_en = 1'b1;

    do_start(8'h10);
    send(2'd1, 4'd1, 5'd1, 5'd0, 5'd0, 12'd5, 1'b1, 32'h00500093, 1'b1);
    chk("latency_not_yet", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("latency_word", bus.out_word, 32'h00500093);
    chk("latency_addr", 32'(bus.out_addr), 32'h10);
    send(2'd3, 4'd2, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1, 32'h402081B3, 1'b1);
    send(2'd1, 4'd9, 5'd5, 5'd5, 5'd0, 12'd3, 1'b1, 32'h4032D293, 1'b1);
    send(2'd2, 4'd0, 5'd0, 5'd2, 5'd8, 12'hFFC, 1'b1, 32'hFE812E23, 1'b1);
    send(2'd0, 4'd0, 5'd1, 5'd2, 5'd0, 12'd0, 1'b1, 32'd0, 1'b0);
    drain();
    chk("err_count_one", 32'(err_count), 32'd1);
    chk("err_pulses_one", 32'(seen_err), 32'd1);

    rdy_mode = 1;
    for (int k = 0; k < 10; k++) send_rand(1'b1);
    drain();
    rdy_mode = 0;
    chk("err_count_unchanged", 32'(err_count), 32'd1);

    do_start(8'hFE);
    for (int k = 0; k < 3; k++) send_rand(1'b1);
    drain();
    chk("addr_after_wrap", 32'(bus.out_addr), 32'h01);

    rdy_mode = 2;
    for (int k = 0; k < 200; k++) send_rand(1'b0);
    rdy_mode = 0;
    drain();
    chk("mix_err_pulses", 32'(seen_err), 32'(exp_err));
    chk("mix_err_count", 32'(err_count), 32'((exp_err > 255) ? 255 : exp_err));

    do_start(8'h20);
    for (int k = 0; k < 300; k++) begin
      send(2'd1, 4'($urandom_range(12, 15)), 5'($urandom), 5'($urandom), 5'd0,
           12'($urandom), 1'b0, 32'd0, 1'b0);
    end
    drain();
    chk("err_count_saturated", 32'(err_count), 32'hFF);
    chk("sat_err_pulses", 32'(seen_err), 32'd300);

    rdy_mode = 3;
    @(posedge clk); #1;
    send_rand(1'b1);
    send_rand(1'b1);
    chk("full_before_reset", 32'(bus.out_valid), 32'd1);
    chk("s1_full_blocks_input", 32'(bus.in_ready), 32'd0);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_word", bus.out_word, 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_start(8'h40);
    send_rand(1'b1);
    drain();
    chk("restart_addr", 32'(bus.out_addr), 32'h41);
    chk("restart_no_err", 32'(err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined instruction encoder: accepts abstract operation tuples (class, ALU op, register indices, immediate) over a valid/ready handshake and emits 32-bit RV32I instruction words with sequential word addresses for the instruction memory loader. It is the inverse of the core's control decode: every word it emits decodes back to the same class and `alu_op`. It sits between the bench/boot program source and instruction-memory write port, and rejects tuples the decode path cannot represent.

## Interface
- `ADDR_W`, 8, width of emitted word address; wraps modulo 2^ADDR_W
- `ERR_W`, 8, width of saturating error counter
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: load `base_addr` into address counter, clear `err_count`
- `base_addr`  in  ADDR_W  start address sampled on `start`
- `in_valid` / `in_ready`  in / out  1  input handshake
- `in_class`  in  2  00 load, 01 immediate, 10 store, 11 reg-reg
- `in_alu_op`  in  4  shared ALU op code (0001 ADD … 1011 SLTU)
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices
- `in_imm`  in  12  immediate, two's complement
- `out_valid` / `out_ready`  out / in  1  output handshake
- `out_word`  out  32  encoded instruction
- `out_addr`  out  ADDR_W  word address of `out_word`
- `err_pulse`  out  1  one-cycle pulse per rejected tuple
- `err_count`  out  ERR_W  rejected tuples, saturating at all-ones

## Operation
- Opcodes: load 0000011, immediate 0010011, store 0100011, reg-reg 0110011.
- Immediate class: ADD→f3 000, SLL 0110→001, SLT 1010→010, SLTU 1011→011, XOR 0011→100, SRL 0111→101/f7 0000000, SRA 1001→101/f7 0100000, OR 0100→110, AND 0101→111. I-type: imm[11:0] in [31:20].
- Shift immediates: [31:25]=f7, [24:20]=in_imm[4:0]; in_imm[11:5]≠0 is illegal.
- Reg-reg class: same funct3 map plus SUB 0010→f3 000/f7 0100000; ADD/others f7 0000000; R-type fields rs2[24:20], rs1[19:15], rd[11:7].
- Load: LW only (f3 010); `in_alu_op` must be 0001. Store: SW (f3 010), S-type split immediate; `in_alu_op` must be 0000.
- Illegal: any other class/op pairing (e.g. SUB in immediate class, alu_op 0000/1100–1111 in arith classes). Illegal tuple is consumed, dropped, never reaches output, does not advance address; `err_pulse` high for one cycle, `err_count`+1 saturating.
- Address counter advances by 1 on each output handshake (`out_valid & out_ready`); wraps from 2^ADDR_W−1 to 0.

## Timing
- Two registered stages: S1 (capture + encode + legality), S2 (output register). Legal tuple accepted at edge N appears on `out_word` after edge N+1 (latency 2 edges when unstalled); full throughput 1/cycle.
- `in_ready = !S1_valid | S1 advances`; S1 advances when S2 empty or draining. S1 illegal entries always advance (dropped), regardless of S2.
- `err_pulse` asserted in the cycle after the illegal tuple is in S1 (aligned to its S1→S2 edge).
- `out_word`/`out_addr` stable while `out_valid & !out_ready`.
- `start` flushes S1 and S2 (in-flight tuples discarded, no error counted), loads address; `in_ready` low during the `start` cycle. `start` with a concurrent output handshake: `start` wins, the word is considered discarded.
- Reset (async assert, sync release): `in_ready`=0 during reset then 1, `out_valid`=0, `out_word`=0, `out_addr`=0, `err_pulse`=0, `err_count`=0, stages empty. Reset mid-transfer discards all in-flight data.

## Structure
- Shared package: class enum, ALU op constants, opcode constants, funct3/funct7 constants — same package the control decode imports, single source of truth.
- Sub-module `instr_field_enc`: combinational class/op → {opcode, f3, f7, format, legal}; parent holds stages, handshake, counters.

## Test plan
- Reset then `start` base 0x10; imm ADD rd=1 rs1=0 imm=5 → out_word 0x00500093 at out_addr 0x10, two edges after accept.
- Reg-reg SUB rd=3 rs1=1 rs2=2 → 0x402081B3; SRA imm rd=5 rs1=5 shamt 3 → 0x4032D293.
- Store SW rs1=2 rs2=8 imm=−4 (0xFFC) → 0xFE812E23; load with alu_op 0000 → dropped, err_pulse once, err_count=1.
- Back-to-back 10 legal tuples, out_ready toggling 1/0 → 10 words in order, contiguous addresses, no loss/duplication, stable data when stalled.
- ADDR_W=8, base 0xFE, 3 words → addresses 0xFE, 0xFF, 0x00; 300 illegal tuples → err_count 0xFF.
- Assert reset with both stages full → out_valid 0 immediately; after release, `start` → clean restart at new base.
